// File: rtl/rv_core_pkg.sv
// Shared core definitions: NOP encoding, default XLEN and the fetch entry layout.
// No ports (package).
package rv_core_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch entry as carried through the fetch queue, MSB first.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] pc_plus_4;
    logic [XLEN_DEFAULT-1:0] instr;
    logic                    fault;
  } fetch_entry_t;

  // Width of a flattened {pc, pc_plus_4, instr, fault} entry for a given XLEN.
  function automatic int unsigned fetch_entry_width(input int unsigned xlen);
    return 3 * xlen + 1;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// fetch_queue: small synchronous FIFO used as the IF fetch queue.
// Ports:
//   clk, reset      clock, async active-high reset
//   push, wdata     enqueue request and payload (accepted when not full, or full with pop)
//   pop             dequeue head (ignored when empty)
//   flush           empty the queue; overrides push and pop
//   rdata           head payload (meaningless when empty)
//   count           occupied entries
//   full, empty     occupancy flags
module fetch_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state: flush wins; a push into a full queue is only legal alongside a pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with on-chip ROM, fetch queue and
// valid/ready handoff to decode. Redirects flush the queue; out-of-range or
// misaligned fetches are delivered as faulting NOP entries.
// Ports:
//   clk, reset                    clock, async active-high reset
//   redirect_valid, redirect_pc   load new fetch PC and flush the queue
//   id_ready                      decode accepts the head entry
//   if_valid                      head entry valid
//   if_pc, if_pc_plus_4           head PC and its stored successor
//   if_instr, if_fault            head instruction and fault flag
//   fq_count                      occupied queue entries (debug)
module if_fetch_unit
  import rv_core_pkg::*;
#(
  parameter int unsigned XLEN           = rv_core_pkg::XLEN_DEFAULT,
  parameter int unsigned IMEM_DEPTH     = 256,
  parameter int unsigned FQ_DEPTH       = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter string       IMEM_INIT_FILE = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  input  logic                      id_ready,
  output logic                      if_valid,
  output logic [XLEN-1:0]           if_pc,
  output logic [XLEN-1:0]           if_pc_plus_4,
  output logic [XLEN-1:0]           if_instr,
  output logic                      if_fault,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int unsigned IDX_W   = $clog2(IMEM_DEPTH);
  localparam int unsigned ENTRY_W = fetch_entry_width(XLEN);

  logic [XLEN-1:0] imem [IMEM_DEPTH];

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [IDX_W-1:0]   word_idx;
  logic               in_range, misaligned, fetch_fault;
  logic [XLEN-1:0]    fetch_instr, fetch_pc_plus_4;
  logic [ENTRY_W-1:0] wentry, hentry;
  logic               pop, push, fq_full, fq_empty;
  logic [XLEN-1:0]    head_pc, head_pc_plus_4, head_instr;
  logic               head_fault;

  // Address decode and fault classification of the current fetch PC.
  always_comb begin
    word_idx        = fetch_pc_q[IDX_W+1:2];
    in_range        = (fetch_pc_q[XLEN-1:IDX_W+2] == '0);
    misaligned      = |fetch_pc_q[1:0];
    fetch_fault     = ~in_range | misaligned;
    fetch_instr     = fetch_fault ? XLEN'(NOP_INSTR) : imem[word_idx];
    fetch_pc_plus_4 = fetch_pc_q + XLEN'(4);
    // Same field order as fetch_entry_t.
    wentry          = {fetch_pc_q, fetch_pc_plus_4, fetch_instr, fetch_fault};
  end

  // Handshake and fetch-PC sequencing; redirect overrides everything.
  always_comb begin
    pop        = if_valid & id_ready;
    push       = ~redirect_valid & (~fq_full | pop);
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_plus_4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fetch_pc_q <= RESET_PC;
    else       fetch_pc_q <= fetch_pc_d;
  end

  fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .rdata (hentry),
    .count (fq_count),
    .full  (fq_full),
    .empty (fq_empty)
  );

  assign {head_pc, head_pc_plus_4, head_instr, head_fault} = hentry;

  // An empty queue presents idle values so decode never sees stale data.
  always_comb begin
    if_valid     = ~fq_empty;
    if_pc        = if_valid ? head_pc        : '0;
    if_pc_plus_4 = if_valid ? head_pc_plus_4 : '0;
    if_instr     = if_valid ? head_instr     : XLEN'(NOP_INSTR);
    if_fault     = if_valid & head_fault;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        rv, rv2;
  logic [31:0] rpc, rpc2;
  logic        rdy, rdy2;
  logic        v1, v2;
  logic [31:0] pc1, pc41, in1, pc2, pc42, in2;
  logic        f1, f2;
  logic [1:0]  cnt1, cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .redirect_valid(rv), .redirect_pc(rpc),
    .id_ready(rdy), .if_valid(v1), .if_pc(pc1), .if_pc_plus_4(pc41),
    .if_instr(in1), .if_fault(f1), .fq_count(cnt1)
  );

  if_fetch_unit #(.IMEM_DEPTH(16)) dut16 (
    .clk(clk), .reset(reset), .redirect_valid(rv2), .redirect_pc(rpc2),
    .id_ready(rdy2), .if_valid(v2), .if_pc(pc2), .if_pc_plus_4(pc42),
    .if_instr(in2), .if_fault(f2), .fq_count(cnt2)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] epc4;
    logic [31:0] einstr;
    logic        ef;
    logic [1:0]  ecnt;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [31:0] m(input int i);
    return 32'h00C0_0000 + 32'(i);
  endfunction

  function automatic vec_t mk(input logic r, input logic [31:0] rp, input logic rd,
                              input logic ev, input logic [31:0] pc, input logic [31:0] ins,
                              input logic f, input logic [1:0] c);
    vec_t x;
    x.rv = r; x.rpc = rp; x.rdy = rd; x.ev = ev; x.epc = pc; x.epc4 = pc + 32'd4;
    x.einstr = ins; x.ef = f; x.ecnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic ev, input logic [31:0] epc,
                      input logic [31:0] ins, input logic ef, input logic [1:0] ec);
    chk({tag, "_valid"}, 32'(v1), 32'(ev));
    chk({tag, "_count"}, 32'(cnt1), 32'(ec));
    chk({tag, "_instr"}, in1, ins);
    chk({tag, "_fault"}, 32'(f1), 32'(ef));
    if (ev) begin
      chk({tag, "_pc"}, pc1, epc);
      chk({tag, "_pc4"}, pc41, epc + 32'd4);
    end
  endtask

  task automatic chk2(input string tag, input logic [31:0] epc, input logic [31:0] ins,
                      input logic ef);
    chk({tag, "_valid"}, 32'(v2), 32'd1);
    chk({tag, "_pc"}, pc2, epc);
    chk({tag, "_instr"}, in2, ins);
    chk({tag, "_fault"}, 32'(f2), 32'(ef));
  endtask

  initial begin
    reset = 1'b1;
    rv = 1'b0; rpc = '0; rdy = 1'b0;
    rv2 = 1'b0; rpc2 = '0; rdy2 = 1'b1;

    // Streaming, stall/saturation, full with pop, redirects, faults, PC wrap.
    vecs[0]  = mk(0, 0, 1, 1, 32'h00, m(0), 0, 1);
    vecs[1]  = mk(0, 0, 1, 1, 32'h04, m(1), 0, 1);
    vecs[2]  = mk(0, 0, 1, 1, 32'h08, m(2), 0, 1);
    vecs[3]  = mk(0, 0, 1, 1, 32'h0C, m(3), 0, 1);
    vecs[4]  = mk(1, 32'h0, 1, 0, 0, NOP, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 32'h00, m(0), 0, 1);
    vecs[6]  = mk(0, 0, 0, 1, 32'h00, m(0), 0, 2);
    vecs[7]  = mk(0, 0, 0, 1, 32'h00, m(0), 0, 2);
    vecs[8]  = mk(0, 0, 0, 1, 32'h00, m(0), 0, 2);
    vecs[9]  = mk(0, 0, 0, 1, 32'h00, m(0), 0, 2);
    vecs[10] = mk(0, 0, 0, 1, 32'h00, m(0), 0, 2);
    vecs[11] = mk(0, 0, 1, 1, 32'h04, m(1), 0, 2);
    vecs[12] = mk(0, 0, 1, 1, 32'h08, m(2), 0, 2);
    vecs[13] = mk(1, 32'h40, 1, 0, 0, NOP, 0, 0);
    vecs[14] = mk(0, 0, 1, 1, 32'h40, m(16), 0, 1);
    vecs[15] = mk(1, 32'h42, 1, 0, 0, NOP, 0, 0);
    vecs[16] = mk(0, 0, 1, 1, 32'h42, NOP, 1, 1);
    vecs[17] = mk(0, 0, 1, 1, 32'h46, NOP, 1, 1);
    vecs[18] = mk(1, 32'h100, 0, 0, 0, NOP, 0, 0);
    vecs[19] = mk(1, 32'h20, 1, 0, 0, NOP, 0, 0);
    vecs[20] = mk(0, 0, 1, 1, 32'h20, m(8), 0, 1);
    vecs[21] = mk(1, 32'hFFFF_FFFC, 1, 0, 0, NOP, 0, 0);
    vecs[22] = mk(0, 0, 1, 1, 32'hFFFF_FFFC, NOP, 1, 1);
    vecs[23] = mk(0, 0, 1, 1, 32'h00, m(0), 0, 1);

    #1;
    for (int i = 0; i < 256; i++) dut.imem[i] = m(i);
    for (int i = 0; i < 16; i++) dut16.imem[i] = m(i);

    #2;
    chk1("reset", 1'b0, 32'h0, NOP, 1'b0, 2'd0);
    chk("reset_pc", pc1, 32'h0);
    chk("reset_pc4", pc41, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      rv = vecs[i].rv; rpc = vecs[i].rpc; rdy = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk1($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr, vecs[i].ef,
           vecs[i].ecnt);
      if (vecs[i].ev) chk($sformatf("v%0d_pc4tab", i), pc41, vecs[i].epc4);
      @(negedge clk);
    end
    rv = 1'b0; rdy = 1'b0;

    // Small ROM: last word in range, first word past the end faults.
    rv2 = 1'b1; rpc2 = 32'h38;
    @(posedge clk); #1;
    chk("d16_redir_valid", 32'(v2), 32'd0);
    @(negedge clk);
    rv2 = 1'b0;
    @(posedge clk); #1;
    chk2("d16_38", 32'h38, m(14), 1'b0);
    @(posedge clk); #1;
    chk2("d16_3c", 32'h3C, m(15), 1'b0);
    @(posedge clk); #1;
    chk2("d16_40", 32'h40, NOP, 1'b1);

    // Fill dut (rdy=0 since last negedge) then assert reset between edges.
    @(posedge clk); #1;
    chk("stall_full_count", 32'(cnt1), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk1("async_reset", 1'b0, 32'h0, NOP, 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    chk1("restart0", 1'b1, 32'h00, m(0), 1'b0, 2'd1);
    @(posedge clk); #1;
    chk1("restart1", 1'b1, 32'h04, m(1), 1'b0, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
